ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one asynchronous SRAM between instruction fetch (IF)
// and the data stage (MEM); each access runs IDLE -> ACCESS -> DONE.
module ram_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_ack,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              ram_pause,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_en_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              ram_data_oe,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  localparam logic [3:0] LAST = 4'(WAIT_CYC);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        starve_q, starve_d;
  logic              sel_mem_q, sel_mem_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;
  logic              en_n_q, en_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              doe_q, doe_d;
  logic              mem_req;
  logic              grant_if;

  // Handshake: a requester raises its request and holds it (with address/data
  // stable) until its one-cycle ack; the arbiter samples requests only in IDLE.
  assign mem_req = mem_re | mem_we;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    sel_mem_d   = sel_mem_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    en_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    doe_d       = 1'b0;
    grant_if    = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || mem_req) begin
          // MEM wins ties unless it has already won twice while IF waited.
          grant_if  = if_req && (!mem_req || starve_q == 2'd2);
          sel_mem_d = !grant_if;
          is_wr_d   = !grant_if && mem_we;
          addr_d    = grant_if ? if_addr : mem_addr;
          wdata_d   = mem_wdata;
          starve_d  = (grant_if || !if_req) ? 2'd0 : starve_q + 2'd1;
          cnt_d     = 4'd0;
          state_d   = ACCESS;
          en_n_d    = 1'b0;
          oe_n_d    = is_wr_d;
          we_n_d    = !is_wr_d;
          doe_d     = is_wr_d;
        end
      end
      ACCESS: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
          if (!is_wr_q) begin
            if (sel_mem_q) mem_rdata_d = ram_rdata;
            else           if_data_d   = ram_rdata;
          end
          if_ack_d  = !sel_mem_q;
          mem_ack_d = sel_mem_q;
        end else begin
          cnt_d  = cnt_q + 4'd1;
          en_n_d = 1'b0;
          oe_n_d = is_wr_q;
          // Write strobe releases one cycle early so address/data hold past it.
          we_n_d = !(is_wr_q && (cnt_q + 4'd1 != LAST));
          doe_d  = is_wr_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      starve_q    <= 2'd0;
      sel_mem_q   <= 1'b0;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      en_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      doe_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      sel_mem_q   <= sel_mem_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      en_n_q      <= en_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      doe_q       <= doe_d;
    end
  end

  assign if_data     = if_data_q;
  assign mem_rdata   = mem_rdata_q;
  assign if_ack      = if_ack_q;
  assign mem_ack     = mem_ack_q;
  assign ram_addr    = addr_q;
  assign ram_wdata   = wdata_q;
  assign ram_en_n    = en_n_q;
  assign ram_oe_n    = oe_n_q;
  assign ram_we_n    = we_n_q;
  assign ram_data_oe = doe_q;
  assign dbg_state   = state_q;
  assign ram_pause   = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural SRAM model, per-scenario tasks, and a
// scoreboard queue of expected read data popped on each ack.
module tb_ram_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int WC = 1;
  localparam int ACK_CYC = WC + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, mem_re, mem_we;
  logic [AW-1:0] if_addr, mem_addr, ram_addr;
  logic [DW-1:0] mem_wdata, if_data, mem_rdata, ram_wdata, ram_rdata;
  logic          if_ack, mem_ack, ram_pause;
  logic          ram_en_n, ram_oe_n, ram_we_n, ram_data_oe;
  logic [1:0]    dbg_state;

  logic [DW-1:0] sram [0:1023];
  logic [DW-1:0] exp_q[$];
  logic [0:0]    exp_who_q[$];
  int            checks = 0;
  int            errors = 0;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(WC)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ack(if_ack),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ram_pause(ram_pause),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .ram_data_oe(ram_data_oe), .dbg_state(dbg_state)
  );

  // clock / external SRAM model
  always #5 clk = ~clk;
  assign ram_rdata = sram[ram_addr[9:0]];
  always @(posedge clk)
    if (!ram_en_n && !ram_we_n && ram_data_oe) sram[ram_addr[9:0]] <= ram_wdata;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic pop_check(input string name, input logic [DW-1:0] got);
    logic [DW-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %h, expected queue empty", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, got, e);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; if_req = 0; mem_re = 0; mem_we = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    tick; tick;
    rst = 1'b0;
    tick;
    checks++;
    if ({dbg_state, if_ack, mem_ack, ram_en_n, ram_oe_n, ram_we_n, ram_data_oe, ram_pause}
        !== {2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl: state=%0d ack=%b%b en/oe/we/doe=%b%b%b%b pause=%b expected 0 00 1110 0",
               dbg_state, if_ack, mem_ack, ram_en_n, ram_oe_n, ram_we_n, ram_data_oe, ram_pause);
    end
    checks++;
    if ({if_data, mem_rdata, ram_wdata} !== '0 || ram_addr !== '0) begin
      errors++;
      $display("FAIL reset_data: if_data=%h mem_rdata=%h ram_addr=%h ram_wdata=%h expected 0",
               if_data, mem_rdata, ram_addr, ram_wdata);
    end
  endtask

  task automatic test_if_read;
    if_req = 1'b1; if_addr = 18'h00010;
    exp_q.push_back(16'h1234);
    #1;
    checks++;
    if (ram_pause !== 1'b1) begin errors++; $display("FAIL if_pause_c0: got %b expected 1", ram_pause); end
    for (int c = 1; c <= ACK_CYC; c++) begin
      tick;
      checks++;
      if (ram_oe_n !== (c < ACK_CYC ? 1'b0 : 1'b1) || ram_we_n !== 1'b1 || ram_data_oe !== 1'b0) begin
        errors++;
        $display("FAIL if_strobes c%0d: oe_n=%b we_n=%b doe=%b", c, ram_oe_n, ram_we_n, ram_data_oe);
      end
      checks++;
      if (if_ack !== (c == ACK_CYC) || ram_pause !== (c != ACK_CYC)) begin
        errors++;
        $display("FAIL if_ack_pause c%0d: ack=%b pause=%b", c, if_ack, ram_pause);
      end
      if (if_ack) begin
        pop_check("if_read_data", if_data);
        if_req = 1'b0;
      end
    end
    if_req = 1'b0;
    tick;
  endtask

  task automatic test_collision;
    if_req = 1'b1; if_addr = 18'h00020;
    mem_we = 1'b1; mem_addr = 18'h00100; mem_wdata = 16'hBEEF;
    exp_q.push_back(16'hA5C3);
    for (int c = 1; c <= 8; c++) begin
      tick;
      checks++;
      if (ram_we_n !== (c != 1) || ram_data_oe !== (c == 1 || c == 2) || ram_oe_n !== (c != 5 && c != 6)) begin
        errors++;
        $display("FAIL coll_strobes c%0d: we_n=%b doe=%b oe_n=%b", c, ram_we_n, ram_data_oe, ram_oe_n);
      end
      checks++;
      if (mem_ack !== (c == 3) || if_ack !== (c == 7)) begin
        errors++;
        $display("FAIL coll_acks c%0d: mem_ack=%b if_ack=%b expected %b %b", c, mem_ack, if_ack, c == 3, c == 7);
      end
      if (mem_ack) mem_we = 1'b0;
      if (if_ack) begin
        pop_check("coll_if_data", if_data);
        if_req = 1'b0;
      end
    end
    checks++;
    if (sram[10'h100] !== 16'hBEEF || mem_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL coll_write: sram=%h mem_rdata=%h expected beef 0000", sram[10'h100], mem_rdata);
    end
  endtask

  task automatic test_rw_both;
    logic [DW-1:0] wd;
    wd = 16'($urandom_range(1, 16'hFFFF));
    mem_re = 1'b1; mem_we = 1'b1; mem_addr = 18'h00140; mem_wdata = wd;
    for (int c = 1; c <= ACK_CYC; c++) begin
      tick;
      checks++;
      if (ram_oe_n !== 1'b1 || ram_we_n !== (c != 1) || mem_ack !== (c == ACK_CYC)) begin
        errors++;
        $display("FAIL rw_both c%0d: oe_n=%b we_n=%b mem_ack=%b", c, ram_oe_n, ram_we_n, mem_ack);
      end
    end
    mem_we = 1'b0; mem_re = 1'b0;
    tick;
    // read back through the data port
    mem_re = 1'b1;
    exp_q.push_back(wd);
    for (int c = 1; c <= ACK_CYC; c++) begin
      tick;
      if (c == ACK_CYC) begin
        checks++;
        if (mem_ack !== 1'b1) begin errors++; $display("FAIL rb_ack: got %b expected 1", mem_ack); end
        pop_check("mem_read_data", mem_rdata);
      end
    end
    mem_re = 1'b0;
    tick;
  endtask

  task automatic test_starvation;
    int acks = 0;
    int cyc = 0;
    logic [0:0] who;
    exp_who_q = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    if_req = 1'b1; if_addr = 18'h00010;
    mem_re = 1'b1; mem_addr = 18'h00020;
    while (acks < 6 && cyc < 60) begin
      tick;
      cyc++;
      if (if_ack || mem_ack) begin
        acks++;
        who = exp_who_q.pop_front();
        checks++;
        if ({if_ack, mem_ack} !== {~who, who}) begin
          errors++;
          $display("FAIL starve_order #%0d: if_ack=%b mem_ack=%b expected mem=%b", acks, if_ack, mem_ack, who);
        end
        if (if_ack) exp_q.push_back(16'h1234);
        else        exp_q.push_back(16'hA5C3);
        pop_check("starve_data", if_ack ? if_data : mem_rdata);
      end
    end
    checks++;
    if (acks != 6) begin errors++; $display("FAIL starve_timeout: got %0d acks expected 6", acks); end
    if_req = 1'b0; mem_re = 1'b0;
    tick; tick; tick; tick;
  endtask

  task automatic test_reset_mid_access;
    mem_we = 1'b1; mem_addr = 18'h00180; mem_wdata = 16'h7777;
    tick; tick;
    checks++;
    if (dbg_state !== 2'd1) begin errors++; $display("FAIL mid_state_pre: got %0d expected 1", dbg_state); end
    rst = 1'b1;
    tick;
    mem_we = 1'b0; rst = 1'b0;
    checks++;
    if ({dbg_state, mem_ack, ram_en_n, ram_oe_n, ram_we_n, ram_data_oe} !== {2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}
        || mem_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset: state=%0d mem_ack=%b en/oe/we/doe=%b%b%b%b mem_rdata=%h",
               dbg_state, mem_ack, ram_en_n, ram_oe_n, ram_we_n, ram_data_oe, mem_rdata);
    end
    for (int c = 0; c < 4; c++) begin
      tick;
      checks++;
      if (mem_ack !== 1'b0 || if_ack !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_ack c%0d: mem_ack=%b if_ack=%b expected 0", c, mem_ack, if_ack);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = '0;
    sram[10'h010] = 16'h1234;
    sram[10'h020] = 16'hA5C3;
    rst = 1'b1;
    test_reset;
    test_if_read;
    test_collision;
    test_rw_both;
    test_starvation;
    test_reset_mid_access;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: %0d entries", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
